// File: rtl/whack_game_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package whack_game_pkg;

  typedef enum logic [2:0] {
    LOBBY = 3'd0,
    ARM   = 3'd1,
    SHOW  = 3'd2,
    HIT   = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [2:0] MIF_LOBBY = 3'd0;
  localparam logic [2:0] MIF_OVER  = 3'd7;

  localparam int                 SCORE_W   = 11;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 11'd2047;

  // A box address is a real target when it lies in 1..num_boxes.
  function automatic logic box_in_range(input logic [2:0] addr, input logic [2:0] num_boxes);
    return (addr != 3'd0) && (addr <= num_boxes);
  endfunction

endpackage

// File: rtl/lfsr_target_gen.sv
// Free-running 3-bit Fibonacci LFSR (x^3 + x^2 + 1), seed 3'b001, period 7.
module lfsr_target_gen (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [2:0] o_value
);

  logic [2:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= 3'b001;
    end else begin
      r_lfsr <= {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/whack_game_sequencer.sv
// Whack-a-mole game controller: lobby, timed rounds with LFSR-picked targets, game-over.
// Define MISS_PENALTY_EN to make wrong-box strikes and window timeouts cost one point.
module whack_game_sequencer
  import whack_game_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int GAME_SECONDS = 60,
  parameter int MOLE_CYCLES  = 75000000,
  parameter int HIT_HOLD     = 12500000,
  parameter int NUM_BOXES    = 6
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start_game,
  input  logic [2:0]         box_address,
  output logic [2:0]         mif_control_signal,
  output logic [SCORE_W-1:0] score,
  output logic [6:0]         seconds_left,
  output logic               play_sound,
  output logic               lobby_sound,
  output logic               game_over
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int WIN_W   = $clog2(MOLE_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HIT_HOLD + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [WIN_W-1:0]   WIN_LOAD   = WIN_W'(MOLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HIT_HOLD - 1);
  localparam logic [6:0]         SECS_INIT  = 7'(GAME_SECONDS);
  localparam logic [2:0]         BOX_MAX    = 3'(NUM_BOXES);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

`ifdef MISS_PENALTY_EN
  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] s);
    return (s == '0) ? s : s - SCORE_W'(1);
  endfunction
`endif

  state_t               r_state, w_state_n;
  logic [2:0]           r_box_p0, r_box_p1, r_box_p2;
  logic                 r_start_prev;
  logic [2:0]           r_target, w_target_n;
  logic [SCORE_W-1:0]   r_score, w_score_n;
  logic [6:0]           r_secs, w_secs_n;
  logic [PRESC_W-1:0]   r_presc, w_presc_n;
  logic [WIN_W-1:0]     r_window, w_window_n;
  logic [HOLD_W-1:0]    r_hold, w_hold_n;

  logic [2:0]           w_lfsr;
  logic                 w_strike, w_hit, w_start, w_active, w_tick, w_lfsr_ok;

  lfsr_target_gen u_lfsr (
    .i_clk   (CLOCK_50),
    .i_rst_n (resetn),
    .o_value (w_lfsr)
  );

  // Stage p0/p1: two-flop synchroniser; stage p2: previous synced sample for edge detect.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_box_p0     <= 3'd0;
      r_box_p1     <= 3'd0;
      r_box_p2     <= 3'd0;
      r_start_prev <= 1'b0;
    end else begin
      r_box_p0     <= box_address;
      r_box_p1     <= r_box_p0;
      r_box_p2     <= r_box_p1;
      r_start_prev <= start_game;
    end
  end

  assign w_strike  = box_in_range(r_box_p1, BOX_MAX) && (r_box_p2 == 3'd0);
  assign w_hit     = w_strike && (r_box_p1 == r_target);
  assign w_start   = start_game && !r_start_prev;
  assign w_active  = (r_state == ARM) || (r_state == SHOW) || (r_state == HIT);
  assign w_tick    = w_active && (r_presc == PRESC_LAST);
  assign w_lfsr_ok = box_in_range(w_lfsr, BOX_MAX) && (w_lfsr != r_target);

`ifdef MISS_PENALTY_EN
  logic w_wrong;
  assign w_wrong = w_strike && (r_box_p1 != r_target);
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= LOBBY;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_target_n = r_target;
    w_score_n  = r_score;
    w_secs_n   = r_secs;
    w_presc_n  = r_presc;
    w_window_n = r_window;
    w_hold_n   = r_hold;

    case (r_state)
      LOBBY, OVER: begin
        if (w_start) begin
          w_state_n  = ARM;
          w_score_n  = '0;
          w_secs_n   = SECS_INIT;
          w_presc_n  = '0;
          w_target_n = 3'd0;
        end
      end
      ARM: begin
        if (w_lfsr_ok) begin
          w_target_n = w_lfsr;
          w_window_n = WIN_LOAD;
          w_state_n  = SHOW;
        end
      end
      SHOW: begin
        if (w_hit) begin
          w_score_n = sat_inc(r_score);
          w_hold_n  = HOLD_LOAD;
          w_state_n = HIT;
        end else begin
`ifdef MISS_PENALTY_EN
          if (w_wrong || (r_window == '0)) begin
            w_score_n = sat_dec(r_score);
          end
`endif
          if (r_window == '0) begin
            w_state_n = ARM;
          end else begin
            w_window_n = r_window - WIN_W'(1);
          end
        end
      end
      HIT: begin
        if (r_hold == '0) begin
          w_state_n = ARM;
        end else begin
          w_hold_n = r_hold - HOLD_W'(1);
        end
      end
      default: w_state_n = LOBBY;
    endcase

    // Game clock runs only while playing; expiry overrides whatever the round wanted.
    if (w_active) begin
      if (w_tick) begin
        w_presc_n = '0;
        w_secs_n  = r_secs - 7'd1;
        if (r_secs <= 7'd1) begin
          w_state_n = OVER;
        end
      end else begin
        w_presc_n = r_presc + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_target <= 3'd0;
      r_score  <= '0;
      r_secs   <= SECS_INIT;
      r_presc  <= '0;
      r_window <= '0;
      r_hold   <= '0;
    end else begin
      r_target <= w_target_n;
      r_score  <= w_score_n;
      r_secs   <= w_secs_n;
      r_presc  <= w_presc_n;
      r_window <= w_window_n;
      r_hold   <= w_hold_n;
    end
  end

  always_comb begin
    mif_control_signal = MIF_LOBBY;
    play_sound         = 1'b0;
    lobby_sound        = 1'b0;
    game_over          = 1'b0;
    case (r_state)
      LOBBY: lobby_sound = 1'b1;
      ARM, SHOW: mif_control_signal = r_target;
      HIT: begin
        mif_control_signal = r_target;
        play_sound         = 1'b1;
      end
      OVER: begin
        mif_control_signal = MIF_OVER;
        game_over          = 1'b1;
      end
      default: mif_control_signal = MIF_LOBBY;
    endcase
  end

  assign score        = r_score;
  assign seconds_left = r_secs;

endmodule

// File: tb/tb_whack_game_sequencer.sv
// Scoreboard bench for whack_game_sequencer: directed games, reset, expiry and score saturation.
module tb_whack_game_sequencer;
  import whack_game_pkg::*;

  localparam int CLK_HZ       = 10;
  localparam int GAME_SECONDS = 3;
  localparam int MOLE_CYCLES  = 20;
  localparam int HIT_HOLD     = 4;

  logic         clk = 1'b0;
  logic         resetn, start_game;
  logic [2:0]   box_address, mif;
  logic [10:0]  score;
  logic [6:0]   secs;
  logic         play_sound, lobby_sound, game_over;

  logic         s_start;
  logic [2:0]   s_box, s_mif;
  logic [10:0]  s_score;
  logic [6:0]   s_secs;
  logic         s_play, s_lobby, s_over;

  always #5 clk = ~clk;

  whack_game_sequencer #(
    .CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME_SECONDS), .MOLE_CYCLES(MOLE_CYCLES),
    .HIT_HOLD(HIT_HOLD), .NUM_BOXES(6)
  ) u_dut (
    .CLOCK_50(clk), .resetn(resetn), .start_game(start_game), .box_address(box_address),
    .mif_control_signal(mif), .score(score), .seconds_left(secs),
    .play_sound(play_sound), .lobby_sound(lobby_sound), .game_over(game_over)
  );

  // Long game so that 2047+ hits fit before time runs out.
  whack_game_sequencer #(
    .CLK_HZ(1000), .GAME_SECONDS(127), .MOLE_CYCLES(20), .HIT_HOLD(1), .NUM_BOXES(6)
  ) u_sat (
    .CLOCK_50(clk), .resetn(resetn), .start_game(s_start), .box_address(s_box),
    .mif_control_signal(s_mif), .score(s_score), .seconds_left(s_secs),
    .play_sound(s_play), .lobby_sound(s_lobby), .game_over(s_over)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t        q_score[$];
  exp_t        q_secs[$];
  exp_t        mon_e;
  logic [10:0] prev_score = '0;
  logic [6:0]  prev_secs  = '0;
  bit          mon_en      = 1'b0;
  bit          mon_secs_en = 1'b0;

  // Monitor: every visible change of score / seconds_left consumes one expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (score !== prev_score) begin
        if (q_score.size() == 0) begin
          n_chk++;
          $display("FAIL score_unexpected: got %0d, expected no change from %0d", score, prev_score);
        end else begin
          mon_e = q_score.pop_front();
          chk("score_val", int'(score), mon_e.val);
          if (mon_e.cyc >= 0) chk("score_cycle", cyc, mon_e.cyc);
        end
      end
      if (mon_secs_en && (secs !== prev_secs)) begin
        if (q_secs.size() == 0) begin
          n_chk++;
          $display("FAIL secs_unexpected: got %0d, expected no change from %0d", secs, prev_secs);
        end else begin
          mon_e = q_secs.pop_front();
          chk("secs_val", int'(secs), mon_e.val);
          chk("secs_cycle", cyc, mon_e.cyc);
        end
      end
    end
    prev_score = score;
    prev_secs  = secs;
  end

  task automatic wait_target(input bit use_sat, input logic [2:0] old,
                             output logic [2:0] tgt, output int n, output bit ok);
    logic [2:0] v;
    ok = 1'b0; n = 0; tgt = 3'd0; v = 3'd0;
    for (int i = 0; i < 40; i++) begin
      v = use_sat ? s_mif : mif;
      if ((v != old) && (v >= 3'd1) && (v <= 3'd6)) begin
        ok  = 1'b1;
        tgt = v;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL wait_target: no new target within 40 cycles, mif=%0d", v);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 1000000", $time);
    $fatal(1, "watchdog");
  end

  int         g, hs, n;
  logic [2:0] t1, t2;
  bit         ok;

  initial begin
    resetn = 1'b1; start_game = 1'b0; box_address = 3'd0; s_start = 1'b0; s_box = 3'd0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_mif", int'(mif), int'(MIF_LOBBY));
    chk("rst_score", int'(score), 0);
    chk("rst_secs", int'(secs), GAME_SECONDS);
    chk("rst_lobby_sound", int'(lobby_sound), 1);
    chk("rst_play_sound", int'(play_sound), 0);
    chk("rst_game_over", int'(game_over), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1; mon_secs_en = 1'b1;

    // Game 1: hit, ignored start pulse, held box counted once, run to OVER.
    g = cyc;
    start_game = 1'b1;
    q_secs.push_back('{val: 2, cyc: g + 11});
    q_secs.push_back('{val: 1, cyc: g + 21});
    q_secs.push_back('{val: 0, cyc: g + 31});
    @(negedge clk);
    start_game = 1'b0;
    chk("g1_arm_mif", int'(mif), 0);
    chk("g1_arm_lobby_sound", int'(lobby_sound), 0);
    wait_target(1'b0, 3'd0, t1, n, ok);
    repeat (2) @(negedge clk);
    box_address = t1; hs = cyc;
    q_score.push_back('{val: 1, cyc: hs + 3});
    n = 0;
    while (!play_sound && n < 10) begin @(negedge clk); n++; end
    chk("hit1_play_rise_cycle", cyc, hs + 3);
    box_address = 3'd0;
    n = 0;
    while (play_sound && n < 20) begin n++; @(negedge clk); end
    chk("hit1_play_len", n, HIT_HOLD);
    n = 0;
    while (mif == t1 && n < 30) begin n++; @(negedge clk); end
    chk("arm_len_1to3", int'(n >= 1 && n <= 3), 1);
    t2 = mif;
    chk("t2_in_range", int'(t2 >= 3'd1 && t2 <= 3'd6), 1);
    box_address = t2; hs = cyc; start_game = 1'b1;
    q_score.push_back('{val: 2, cyc: hs + 3});
    @(negedge clk);
    start_game = 1'b0;
    repeat (29) @(negedge clk);
    box_address = 3'd0;
    while (cyc < g + 32) @(negedge clk);
    chk("g1_over_mif", int'(mif), int'(MIF_OVER));
    chk("g1_over_flag", int'(game_over), 1);
    chk("g1_over_score", int'(score), 2);
    chk("g1_over_secs", int'(secs), 0);
    chk("g1_over_sounds", int'({play_sound, lobby_sound}), 0);

    // Game 2 from OVER: fresh start, silent timeout, strike on the expiry cycle.
    g = cyc;
    start_game = 1'b1;
    q_score.push_back('{val: 0, cyc: g + 1});
    q_secs.push_back('{val: 3, cyc: g + 1});
    q_secs.push_back('{val: 2, cyc: g + 11});
    q_secs.push_back('{val: 1, cyc: g + 21});
    q_secs.push_back('{val: 0, cyc: g + 31});
    @(negedge clk);
    start_game = 1'b0;
    chk("g2_arm_mif", int'(mif), 0);
    chk("g2_arm_over_flag", int'(game_over), 0);
    chk("g2_start_score", int'(score), 0);
    chk("g2_start_secs", int'(secs), GAME_SECONDS);
    wait_target(1'b0, 3'd0, t1, n, ok);
    n = 0;
    while (mif == t1 && n < 40) begin n++; @(negedge clk); end
    chk("timeout_show_plus_arm_21to23", int'(n >= 21 && n <= 23), 1);
    chk("timeout_score_kept", int'(score), 0);
    t2 = mif;
    while (cyc < g + 28) @(negedge clk);
    box_address = t2;
    q_score.push_back('{val: 1, cyc: g + 31});
    while (cyc < g + 32) @(negedge clk);
    box_address = 3'd0;
    chk("g2_over_mif", int'(mif), int'(MIF_OVER));
    chk("g2_expiry_strike_score", int'(score), 1);
    chk("g2_over_secs", int'(secs), 0);

    // Game 3: score a hit, then reset asynchronously during the next SHOW.
    mon_secs_en = 1'b0;
    g = cyc;
    start_game = 1'b1;
    q_score.push_back('{val: 0, cyc: g + 1});
    @(negedge clk);
    start_game = 1'b0;
    wait_target(1'b0, 3'd0, t1, n, ok);
    box_address = t1; hs = cyc;
    q_score.push_back('{val: 1, cyc: hs + 3});
    n = 0;
    while (!play_sound && n < 10) begin @(negedge clk); n++; end
    box_address = 3'd0;
    n = 0;
    while (play_sound && n < 20) begin n++; @(negedge clk); end
    wait_target(1'b0, t1, t2, n, ok);
    q_score.push_back('{val: 0, cyc: -1});
    #2 resetn = 1'b0;
    #1;
    chk("rst_show_mif", int'(mif), 0);
    chk("rst_show_score", int'(score), 0);
    chk("rst_show_lobby_sound", int'(lobby_sound), 1);
    chk("rst_show_secs", int'(secs), GAME_SECONDS);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_lobby", int'(lobby_sound), 1);
    mon_en = 1'b0;

    // Saturation: 2050 hits on the long-game instance.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    t1 = 3'd0;
    for (int i = 1; i <= 2050; i++) begin
      wait_target(1'b1, t1, t2, n, ok);
      if (!ok) break;
      t1 = t2;
      s_box = t2;
      repeat (3) @(negedge clk);
      s_box = 3'd0;
      if (i == 2047) chk("sat_reach_2047", int'(s_score), 2047);
    end
    chk("sat_hold_2047", int'(s_score), 2047);
    chk("sat_still_playing", int'(s_over), 0);

    chk("score_queue_drained", q_score.size(), 0);
    chk("secs_queue_drained", q_secs.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/whack_game_sequencer.md
Name: whack_game_sequencer

Overview:
- Top-level game controller for the whack-a-mole board.
- Sequences lobby → rounds → game-over and picks each target box from an internal LFSR.
- Drives `mif_control_signal` to the VGA level selector.
- Synchronises and edge-detects the Arduino `box_address`, scores hits, runs the game countdown, and raises `play_sound`/`lobby_sound` for the audio units.

Parameters:
- CLK_HZ, 50000000, CLOCK_50 cycles per game second
- GAME_SECONDS, 60, round length in seconds (1..127)
- MOLE_CYCLES, 75000000, cycles a target stays lit before a miss
- HIT_HOLD, 12500000, cycles `play_sound` stays high after a hit
- NUM_BOXES, 6, valid target addresses 1..NUM_BOXES (≤6)

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start_game  in  1  synchronous; rising edge starts a game
- box_address  in  3  raw sensor address; 0 = idle, 1..6 = box struck
- mif_control_signal  out  3  0 = lobby screen, 1..6 = lit box, 7 = game-over screen
- score  out  11  hits this game, saturating
- seconds_left  out  7  countdown
- play_sound  out  1  hit sound enable
- lobby_sound  out  1  lobby music enable
- game_over  out  1  high in OVER

Behaviour:
- Reset: resetn low forces LOBBY immediately (async). Outputs: mif=0, score=0, seconds_left=GAME_SECONDS, play_sound=0, lobby_sound=1, game_over=0. LFSR=3'b001; prescaler, window and hold counters=0.
- box_address path: 2-flop synchroniser, then a previous-sample register. Strike = synced≠0 && prev==0. A held box counts once. A strike is acted on at the 3rd CLOCK_50 edge after box_address settles nonzero. Strikes with address >NUM_BOXES are ignored.
- start_game is edge-detected internally (registered previous value).
- LOBBY: mif=0, lobby_sound=1. On start_game edge: score←0, seconds_left←GAME_SECONDS, prescaler←0, go to ARM.
- ARM: LFSR (x³+x²+1) steps every cycle in all states.
  - If the LFSR value is 0, >NUM_BOXES, or equals the previous target: stay in ARM.
  - Otherwise: target←value, window←MOLE_CYCLES−1, go to SHOW. Typical 1–3 cycles.
  - mif holds the previous target during ARM (0 on the first round).
- SHOW: mif=target.
  - Strike==target: score+1, saturating at 2047; hold←HIT_HOLD−1; go to HIT.
  - Strike≠target: no effect (base build).
  - window==0: go to ARM; the miss is silent.
  - Otherwise window decrements.
- HIT: play_sound=1, mif=target. Hold decrements; at 0 go to ARM and play_sound drops the next cycle.
- Countdown: the prescaler counts only in ARM/SHOW/HIT. Each wrap at CLK_HZ−1 decrements seconds_left.
  - When seconds_left would reach 0, go to OVER that cycle, overriding any other transition.
  - A correct strike in the same cycle is still scored.
- OVER: mif=7, game_over=1, play_sound=0, lobby_sound=0. score and seconds_left (0) are held. A start_game edge starts a fresh game exactly as from LOBBY.
- lobby_sound=1 only in LOBBY.
- start_game edges in ARM/SHOW/HIT are ignored.

Optional Feature:
- Macro: MISS_PENALTY_EN.
- When defined:
  - A wrong-box strike in SHOW decrements score, saturating at 0, and stays in SHOW.
  - A window timeout also decrements score, saturating at 0.
- When undefined: wrong strikes and timeouts leave score unchanged.

Decomposition:
- Package whack_game_pkg:
  - state enum {LOBBY, ARM, SHOW, HIT, OVER}
  - constants MIF_LOBBY=3'd0 and MIF_OVER=3'd7
  - SCORE_W=11 and SCORE_MAX=2047
- Sub-module lfsr_target_gen: 3-bit Fibonacci LFSR with async active-low reset, seed 3'b001, free-running; outputs current value. Filtering stays in the sequencer.

Test Plan:
(bench parameters: CLK_HZ=10, GAME_SECONDS=3, MOLE_CYCLES=20, HIT_HOLD=4)
- Reset mid-SHOW (resetn low 2 cycles) → mif=0, score=0, lobby_sound=1, seconds_left=3, asynchronously before the next edge.
- start_game pulse, then strike box_address=target 2 cycles after SHOW entry → score=1 on the 3rd edge; play_sound high exactly 4 cycles; then ARM with a new target ≠ old.
- Hold box_address=target for 30 cycles → score increments once only.
- No strikes → SHOW lasts 20 cycles, then ARM; score stays 0. With MISS_PENALTY_EN and score=1 → score=0; a second timeout keeps 0.
- Run 30 play cycles → seconds_left 3→2→1 then OVER; mif=7, game_over=1, score held. A correct strike on the expiry cycle is still counted.
- In OVER, pulse start_game → score=0, seconds_left=3, state ARM. Force 2047 hits → score stays 2047.
